// File: rtl/segmenter_input_arbiter.sv
// Round-robin message arbiter for the segmenter input: 1 idle cycle per arbitration, zero-latency beats while granted,
// iSEG_READY backpressures only the granted channel. Define SEG_ARB_WATCHDOG_EN for the stalled-grant abort (oWDOG_ABORT).
module segmenter_input_arbiter #(
  parameter int N_CH           = 4,
  parameter int AXI_FRAME_SIZE = 128,
  parameter int WDOG_CYCLES    = 256
) (
  input  logic                           iClk,
  input  logic                           iRst,
  input  logic [N_CH*AXI_FRAME_SIZE-1:0] iREQ_DATA,
  input  logic [N_CH-1:0]                iREQ_VALID,
  input  logic [N_CH-1:0]                iREQ_LAST,
  output logic [N_CH-1:0]                oREQ_READY,
  output logic [AXI_FRAME_SIZE-1:0]      oSEG_DATA,
  output logic                           oSEG_VALID,
  input  logic                           iSEG_READY,
  output logic                           oSEG_LAST,
  output logic                           oSEG_FIRST,
  output logic [$clog2(N_CH)-1:0]        oSEG_CH,
  output logic                           oBUSY
`ifdef SEG_ARB_WATCHDOG_EN
  ,
  output logic                           oWDOG_ABORT
`endif
);
  localparam int CW = $clog2(N_CH);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             grant_q, grant_d;
  logic [CW-1:0]             last_grant_q, last_grant_d;
  logic                      first_pend_q, first_pend_d;
  logic [AXI_FRAME_SIZE-1:0] req_dat [N_CH];
  logic                      arb_found;
  logic [CW-1:0]             arb_ch;
  logic                      busy, g_vld, g_last, xfer;
  int                        idx;

`ifdef SEG_ARB_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          wdog_abort_q, wdog_abort_d;
`endif

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign req_dat[k] = iREQ_DATA[k*AXI_FRAME_SIZE +: AXI_FRAME_SIZE];
  end

  // Search starts just after the last served channel, so it ends up lowest priority.
  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    idx       = 0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(last_grant_q) + i) % N_CH;
      if (!arb_found && iREQ_VALID[idx]) begin
        arb_found = 1'b1;
        arb_ch    = CW'(idx);
      end
    end
  end

  assign busy       = (state_q == ST_GRANT);
  assign g_vld      = iREQ_VALID[grant_q];
  assign g_last     = iREQ_LAST[grant_q];
  assign oSEG_DATA  = req_dat[grant_q];
  assign oSEG_VALID = busy & g_vld;
  assign oSEG_LAST  = busy & g_last;
  assign oSEG_FIRST = first_pend_q & oSEG_VALID;
  assign oSEG_CH    = grant_q;
  assign oBUSY      = busy;
  assign xfer       = oSEG_VALID & iSEG_READY;

  always_comb begin
    oREQ_READY = '0;
    if (busy) oREQ_READY[grant_q] = iSEG_READY;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    first_pend_d = first_pend_q;
`ifdef SEG_ARB_WATCHDOG_EN
    wdog_cnt_d   = wdog_cnt_q;
    wdog_abort_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          state_d      = ST_GRANT;
          grant_d      = arb_ch;
          first_pend_d = 1'b1;
`ifdef SEG_ARB_WATCHDOG_EN
          wdog_cnt_d   = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (xfer) first_pend_d = 1'b0;
        if (xfer && g_last) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
`ifdef SEG_ARB_WATCHDOG_EN
        // Only consecutive cycles with the granted valid low count toward the abort.
        if (g_vld) begin
          wdog_cnt_d = '0;
        end else begin
          wdog_cnt_d = wdog_cnt_q + 1'b1;
          if (wdog_cnt_q == WW'(WDOG_CYCLES - 1)) begin
            wdog_abort_d = 1'b1;
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= CW'(N_CH - 1);
      first_pend_q <= 1'b1;
`ifdef SEG_ARB_WATCHDOG_EN
      wdog_cnt_q   <= '0;
      wdog_abort_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      first_pend_q <= first_pend_d;
`ifdef SEG_ARB_WATCHDOG_EN
      wdog_cnt_q   <= wdog_cnt_d;
      wdog_abort_q <= wdog_abort_d;
`endif
    end
  end

`ifdef SEG_ARB_WATCHDOG_EN
  assign oWDOG_ABORT = wdog_abort_q;
`endif

endmodule

// File: tb/tb_segmenter_input_arbiter.sv
// Bench for segmenter_input_arbiter: vector table, directed corner sequences, random traffic vs. a message-level model.
module tb_segmenter_input_arbiter;
  localparam int N    = 4;
  localparam int W    = 32;
  localparam int WDOG = 8;

  logic           iClk = 1'b0;
  logic           iRst;
  logic [N*W-1:0] iREQ_DATA;
  logic [N-1:0]   iREQ_VALID, iREQ_LAST, oREQ_READY;
  logic [W-1:0]   oSEG_DATA;
  logic           oSEG_VALID, iSEG_READY, oSEG_LAST, oSEG_FIRST, oBUSY;
  logic [1:0]     oSEG_CH;
`ifdef SEG_ARB_WATCHDOG_EN
  logic           oWDOG_ABORT;
`endif

  logic [W-1:0] d [N];
  assign iREQ_DATA = {d[3], d[2], d[1], d[0]};

  int n_err = 0;
  int n_chk = 0;

  always #5 iClk = ~iClk;

  segmenter_input_arbiter #(.N_CH(N), .AXI_FRAME_SIZE(W), .WDOG_CYCLES(WDOG)) dut (
    .iClk(iClk), .iRst(iRst),
    .iREQ_DATA(iREQ_DATA), .iREQ_VALID(iREQ_VALID), .iREQ_LAST(iREQ_LAST), .oREQ_READY(oREQ_READY),
    .oSEG_DATA(oSEG_DATA), .oSEG_VALID(oSEG_VALID), .iSEG_READY(iSEG_READY),
    .oSEG_LAST(oSEG_LAST), .oSEG_FIRST(oSEG_FIRST), .oSEG_CH(oSEG_CH), .oBUSY(oBUSY)
`ifdef SEG_ARB_WATCHDOG_EN
    , .oWDOG_ABORT(oWDOG_ABORT)
`endif
  );

  typedef struct {
    bit         rst;
    logic [3:0] vld, last;
    logic       rdy;
    logic       e_vld;
    logic [3:0] e_rdy;
    logic [1:0] e_ch;
    logic       e_first, e_last, e_busy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(input bit r, input logic [3:0] vl, input logic [3:0] ls, input logic rd,
                             input logic ev, input logic [3:0] er, input logic [1:0] ec,
                             input logic ef, input logic el, input logic eb);
    vec_t t;
    t.rst = r; t.vld = vl; t.last = ls; t.rdy = rd;
    t.e_vld = ev; t.e_rdy = er; t.e_ch = ec; t.e_first = ef; t.e_last = el; t.e_busy = eb;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge iClk);
    #1;
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    iREQ_VALID = '0;
    iREQ_LAST = '0;
    iSEG_READY = 1'b0;
    next_cycle();
    next_cycle();
    iRst = 1'b0;
  endtask

  // Reference model state: owner -1 means no grant held.
  int         m_owner, m_last, m_ch, m_stall;
  bit         m_first, m_ab, m_ab_n, found;
  int         g, c, xk, stalls, pulses, abort_cyc, post_ch;
  int         rem [N];
  logic [3:0] er;
  int         got[$];
  int         exp4[7] = '{1, 1, 1, 1, 1, 3, 1};
  bit         drop3;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < N; k++) d[k] = 32'hD0D0_0000 + k;
    iRst = 1'b1; iREQ_VALID = '0; iREQ_LAST = '0; iSEG_READY = 1'b0;

    // ch0 alone, 3-beat message
    tv.push_back(v(1, 4'b0001, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b0001, 4'b0000, 1, 1, 4'b0001, 0, 1, 0, 1));
    tv.push_back(v(0, 4'b0001, 4'b0000, 1, 1, 4'b0001, 0, 0, 0, 1));
    tv.push_back(v(0, 4'b0001, 4'b0001, 1, 1, 4'b0001, 0, 0, 1, 1));
    tv.push_back(v(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 0));
    // all four channels, 2-beat messages: order 0,1,2,3,0
    tv.push_back(v(1, 4'b1111, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b1111, 4'b0000, 1, 1, 4'b0001, 0, 1, 0, 1));
    tv.push_back(v(0, 4'b1111, 4'b0001, 1, 1, 4'b0001, 0, 0, 1, 1));
    tv.push_back(v(0, 4'b1111, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b1111, 4'b0000, 1, 1, 4'b0010, 1, 1, 0, 1));
    tv.push_back(v(0, 4'b1111, 4'b0010, 1, 1, 4'b0010, 1, 0, 1, 1));
    tv.push_back(v(0, 4'b1111, 4'b0000, 1, 0, 4'b0000, 1, 0, 0, 0));
    tv.push_back(v(0, 4'b1111, 4'b0000, 1, 1, 4'b0100, 2, 1, 0, 1));
    tv.push_back(v(0, 4'b1111, 4'b0100, 1, 1, 4'b0100, 2, 0, 1, 1));
    tv.push_back(v(0, 4'b1111, 4'b0000, 1, 0, 4'b0000, 2, 0, 0, 0));
    tv.push_back(v(0, 4'b1111, 4'b0000, 1, 1, 4'b1000, 3, 1, 0, 1));
    tv.push_back(v(0, 4'b1111, 4'b1000, 1, 1, 4'b1000, 3, 0, 1, 1));
    tv.push_back(v(0, 4'b1111, 4'b0000, 1, 0, 4'b0000, 3, 0, 0, 0));
    tv.push_back(v(0, 4'b1111, 4'b0000, 1, 1, 4'b0001, 0, 1, 0, 1));
    tv.push_back(v(0, 4'b1111, 4'b0001, 1, 1, 4'b0001, 0, 0, 1, 1));
    tv.push_back(v(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 0));

    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      iREQ_VALID = tv[i].vld; iREQ_LAST = tv[i].last; iSEG_READY = tv[i].rdy;
      @(negedge iClk);
      chk("tv_vld", oSEG_VALID, tv[i].e_vld);
      chk("tv_rdy", oREQ_READY, tv[i].e_rdy);
      chk("tv_ch", oSEG_CH, tv[i].e_ch);
      chk("tv_first", oSEG_FIRST, tv[i].e_first);
      chk("tv_last", oSEG_LAST, tv[i].e_last);
      chk("tv_busy", oBUSY, tv[i].e_busy);
      if (tv[i].e_vld) chk("tv_data", oSEG_DATA, d[tv[i].e_ch]);
      next_cycle();
    end

    // ch2 4-beat message with stalls on beats 2 and 3; ch0 waits throughout
    do_reset();
    iREQ_VALID = 4'b0100; iREQ_LAST = 4'b0000; iSEG_READY = 1'b1; d[2] = 32'h2000_0001;
    @(negedge iClk);
    chk("t3_idle_busy", oBUSY, 0);
    next_cycle();
    iREQ_VALID = 4'b0101;
    for (int b = 1; b <= 4; b++) begin
      d[2] = 32'h2000_0000 + b;
      iREQ_LAST = (b == 4) ? 4'b0101 : 4'b0001;
      stalls = (b == 2 || b == 3) ? 5 : 0;
      for (int s = 0; s <= stalls; s++) begin
        iSEG_READY = (s == stalls);
        @(negedge iClk);
        chk("t3_ch", oSEG_CH, 2);
        chk("t3_vld", oSEG_VALID, 1);
        chk("t3_rdy", oREQ_READY, (s == stalls) ? 4'b0100 : 4'b0000);
        chk("t3_data", oSEG_DATA, 32'h2000_0000 + b);
        chk("t3_first", oSEG_FIRST, b == 1);
        chk("t3_last", oSEG_LAST, b == 4);
        next_cycle();
      end
    end
    iREQ_VALID = 4'b0001;
    @(negedge iClk);
    chk("t3_gap_busy", oBUSY, 0);
    chk("t3_gap_ch", oSEG_CH, 2);
    next_cycle();
    @(negedge iClk);
    chk("t3_ch0_rdy", oREQ_READY, 4'b0001);
    chk("t3_ch0_first", oSEG_FIRST, 1);
    next_cycle();
    iREQ_VALID = '0;

    // ch1 streams single-beat messages, ch3 joins at cycle 10
    do_reset();
    iREQ_VALID = 4'b0010; iREQ_LAST = 4'b1111; iSEG_READY = 1'b1;
    got.delete(); drop3 = 0;
    for (int cy = 0; cy < 40 && got.size() < 7; cy++) begin
      if (cy == 10) iREQ_VALID[3] = 1'b1;
      @(negedge iClk);
      if (oSEG_VALID && iSEG_READY) begin
        got.push_back(int'(oSEG_CH));
        if (oSEG_CH == 2'd3) drop3 = 1;
      end
      next_cycle();
      if (drop3) iREQ_VALID[3] = 1'b0;
    end
    chk("t4_count", got.size(), 7);
    for (int i = 0; i < 7 && i < got.size(); i++) chk("t4_order", got[i], exp4[i]);
    iREQ_VALID = '0;

    // reset in the middle of a ch2 message
    do_reset();
    iREQ_VALID = 4'b0100; iREQ_LAST = 4'b0000; iSEG_READY = 1'b1;
    @(negedge iClk);
    next_cycle();
    @(negedge iClk);
    chk("t5_pre_ch", oSEG_CH, 2);
    next_cycle();
    iRst = 1'b1;
    @(negedge iClk);
    next_cycle();
    iRst = 1'b0; iREQ_VALID = 4'b0101;
    @(negedge iClk);
    chk("t5_vld", oSEG_VALID, 0);
    chk("t5_rdy", oREQ_READY, 0);
    chk("t5_busy", oBUSY, 0);
    chk("t5_ch", oSEG_CH, 0);
    chk("t5_first", oSEG_FIRST, 0);
    next_cycle();
    @(negedge iClk);
    chk("t5_win_ch", oSEG_CH, 0);
    chk("t5_win_rdy", oREQ_READY, 4'b0001);
    chk("t5_win_first", oSEG_FIRST, 1);
    next_cycle();
    iREQ_VALID = '0;

`ifdef SEG_ARB_WATCHDOG_EN
    // ch1 goes quiet after its first beat; ch2 waits
    do_reset();
    iREQ_VALID = 4'b0010; iREQ_LAST = 4'b0000; iSEG_READY = 1'b1;
    pulses = 0; abort_cyc = -1; post_ch = -1;
    for (int cy = 0; cy < 20; cy++) begin
      if (cy == 2) begin iREQ_VALID = 4'b0100; iREQ_LAST = 4'b0100; end
      @(negedge iClk);
      if (cy == 0) chk("t6_abort_rst", oWDOG_ABORT, 0);
      if (oWDOG_ABORT) begin
        pulses++; abort_cyc = cy;
        chk("t6_abort_ch", oSEG_CH, 1);
      end
      if (abort_cyc >= 0 && post_ch < 0 && oSEG_VALID && iSEG_READY) post_ch = int'(oSEG_CH);
      next_cycle();
    end
    chk("t6_pulses", pulses, 1);
    chk("t6_abort_cyc", abort_cyc, 10);
    chk("t6_next_ch", post_ch, 2);
    iREQ_VALID = '0;
`endif

    // random traffic against the message-level model
    do_reset();
    m_owner = -1; m_last = N - 1; m_ch = 0; m_first = 1; m_stall = 0; m_ab = 0;
    for (int k = 0; k < N; k++) rem[k] = 0;
    for (int cy = 0; cy < 3000; cy++) begin
      iSEG_READY = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < N; k++) begin
        if (!iREQ_VALID[k] && $urandom_range(0, 2) == 0) begin
          if (rem[k] == 0) rem[k] = $urandom_range(1, 4);
          iREQ_VALID[k] = 1'b1;
          iREQ_LAST[k] = (rem[k] == 1);
          d[k] = $urandom;
        end
      end
      @(negedge iClk);
      if (m_owner < 0) begin
        chk("rnd_vld", oSEG_VALID, 0);
        chk("rnd_rdy", oREQ_READY, 0);
        chk("rnd_busy", oBUSY, 0);
        chk("rnd_first", oSEG_FIRST, 0);
        chk("rnd_ch", oSEG_CH, m_ch);
      end else begin
        g = m_owner;
        er = '0;
        if (iSEG_READY) er[g] = 1'b1;
        chk("rnd_vld", oSEG_VALID, iREQ_VALID[g]);
        chk("rnd_rdy", oREQ_READY, er);
        chk("rnd_busy", oBUSY, 1);
        chk("rnd_ch", oSEG_CH, g);
        chk("rnd_first", oSEG_FIRST, m_first & iREQ_VALID[g]);
        if (iREQ_VALID[g]) begin
          chk("rnd_data", oSEG_DATA, d[g]);
          chk("rnd_last", oSEG_LAST, iREQ_LAST[g]);
        end
      end
`ifdef SEG_ARB_WATCHDOG_EN
      chk("rnd_abort", oWDOG_ABORT, m_ab);
`endif
      xk = -1; m_ab_n = 0;
      if (m_owner < 0) begin
        if (|iREQ_VALID) begin
          found = 0;
          for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (!found && iREQ_VALID[c]) begin found = 1; m_owner = c; end
          end
          m_ch = m_owner; m_first = 1; m_stall = 0;
        end
      end else begin
        g = m_owner;
        if (iREQ_VALID[g] && iSEG_READY) begin
          xk = g; m_first = 0;
          if (iREQ_LAST[g]) begin m_last = g; m_owner = -1; end
        end
`ifdef SEG_ARB_WATCHDOG_EN
        if (iREQ_VALID[g]) m_stall = 0;
        else begin
          m_stall++;
          if (m_stall == WDOG) begin m_last = g; m_owner = -1; m_ab_n = 1; end
        end
`endif
      end
      m_ab = m_ab_n;
      next_cycle();
      if (xk >= 0) begin
        rem[xk]--;
        iREQ_VALID[xk] = 1'b0;
        iREQ_LAST[xk] = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
